pixel_pool_buffer: RTL and testbench
====================================

Name: pixel_pool_buffer

Overview:
- Front-end stage directly upstream of FW_logic_FSM_wrapper.
- Accepts a raster-order 28x28 8-bit pixel stream and 2x2 average-pools it to 14x14, with a scale that fits the MLP's 7-bit-magnitude input range.
- Holds the 196 pooled pixels in a packed register vector, pulses start to the classifier, then blocks new input until the classifier reports done.

Parameters:
- IMG_DIM, 28, input image side length in pixels; must be even.
- DATA_WIDTH, 8, bits per input and per output pixel.
- POOL_SHIFT, 3, right shift applied to the 2x2 sum (average, then halved).
- OUT_DIM, IMG_DIM/2, derived output side length (14). Not user-set.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pixel_in  in  DATA_WIDTH  input pixel, unsigned.
- pixel_valid  in  1  pixel_in valid this cycle.
- pixel_sof  in  1  marks the first pixel (row 0, col 0) of a frame; qualified by pixel_valid.
- pixel_ready  out  1  block can accept a pixel this cycle.
- mlp_done  in  1  classifier done pulse; connects to the wrapper's done output.
- pixels_out  out  DATA_WIDTH*OUT_DIM*OUT_DIM  packed pooled image; connects to pixels_in.
- start  out  1  one-cycle start pulse to the classifier.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, row=0, col=0, all partial sums=0, pixels_out=0, start=0, busy=0, pixel_ready=1.
- Handshake: a pixel is accepted on a clk edge where pixel_valid && pixel_ready. Gaps in pixel_valid are allowed. Counters advance only on accept.
- pixel_ready=1 in IDLE and FILL, 0 in START and WAIT_DONE.
- Counters: col runs 0..IMG_DIM-1 and wraps to 0 while row increments; row runs 0..IMG_DIM-1.
- Line buffer: OUT_DIM partial sums, each DATA_WIDTH+2 bits (10). A 1-entry previous-pixel register holds the even-column pixel.
  - Even row, odd col: partial[col/2] <= prev + pixel_in.
  - Odd row, odd col: sum = partial[col/2] + prev + pixel_in (10 bits, max 1020, no overflow). Write sum>>POOL_SHIFT, truncated, into output index k = (row/2)*OUT_DIM + col/2.
- Packing: output pixel k occupies pixels_out[W-1-DATA_WIDTH*k -: DATA_WIDTH], with W = total width. Index 0 (top-left) is in the MSBs. The value range is 0..127, so the MSB is always 0.
- State IDLE:
  - Accepted pixel with pixel_sof=1: treat it as row 0/col 0, go to FILL, counters advance to col=1.
  - Accepted pixel with pixel_sof=0: consumed and discarded.
- State FILL:
  - Accept pixels.
  - Accepted pixel with pixel_sof=1: restart the frame. The pixel becomes row 0/col 0. Partial sums need no clearing (even rows overwrite them). pixels_out keeps stale entries until overwritten.
  - Accept of pixel (IMG_DIM-1, IMG_DIM-1): go to START. pixels_out is complete at the same edge.
- State START: start=1 for exactly one cycle, then WAIT_DONE.
- State WAIT_DONE:
  - pixels_out held stable.
  - mlp_done=1: go to IDLE next cycle.
  - mlp_done asserted during START: ignored.
- Latency: last pixel accepted at edge N; start=1 during cycle N..N+1; pixel_ready=0 from edge N.
- Stability: pixels_out changes only on odd-row/odd-col accepts in FILL, and on reset.
- Reset mid-operation (any state) returns to reset values on the next edge. Any pending start is cancelled.

Test Plan:
- Uniform frame: SOF plus 784 pixels of 0xFF, valid every cycle. Required: all 196 outputs = 0x7F; start pulses exactly once, 1 cycle after the 784th accept; pixel_ready=0 from then on.
- Known block pattern: quadrant (r/2,c/2) pixels = {8,8,8,8} for out idx 0, {255,0,0,0} for idx 1, zeros elsewhere. Required: pixels_out[1567:1560]=4, [1559:1552]=31, all others 0.
- Backpressure and release:
  - Hold mlp_done=0 for 500 cycles after start. Required: pixel_ready=0, pixels_out constant, busy=1.
  - Pulse mlp_done. Required: IDLE next cycle, pixel_ready=1.
  - Second frame: all zeros. Required: all outputs 0.
- Sparse valid: same uniform-0xFF frame with pixel_valid toggling 1/0 randomly. Required: identical result to the first case; start is still exactly one pulse.
- Stream anomalies:
  - Pixels without SOF in IDLE. Required: ignored, busy=0.
  - SOF re-asserted at pixel 300 of a frame, then a full 784-pixel frame of value 0x10. Required: all outputs 0x08; exactly one start.
- Reset mid-frame after 400 pixels. Required: pixels_out=0, busy=0, start never asserted. A following full frame processes correctly.

Source files
------------

// File: rtl/pixel_pool_buffer.sv
// 2x2 average-pool front end: raster 28x28 pixel stream in, 14x14 pooled image held for the
// classifier, with a start pulse out and input blocked until the classifier reports done.
module pixel_pool_buffer #(
    parameter int unsigned IMG_DIM    = 28,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned POOL_SHIFT = 3
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic [DATA_WIDTH-1:0]                                pixel_in,
    input  logic                                                 pixel_valid,
    input  logic                                                 pixel_sof,
    output logic                                                 pixel_ready,
    input  logic                                                 mlp_done,
    output logic [DATA_WIDTH*(IMG_DIM/2)*(IMG_DIM/2)-1:0]        pixels_out,
    output logic                                                 start,
    output logic                                                 busy
);

    localparam int unsigned OUT_DIM = IMG_DIM / 2;
    localparam int unsigned W       = DATA_WIDTH * OUT_DIM * OUT_DIM;
    localparam int unsigned CW      = $clog2(IMG_DIM);
    localparam int unsigned SW      = DATA_WIDTH + 2;
    localparam logic [CW-1:0] LAST  = CW'(IMG_DIM - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] FILL      = 2'd1;
    localparam logic [1:0] START     = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [SW-1:0]         partial_q [OUT_DIM];
    logic [SW-1:0]         partial_d [OUT_DIM];
    logic [W-1:0]          pixels_q, pixels_d;

    logic                  accept;
    logic                  take;
    logic [CW-1:0]         row_eff;
    logic [CW-1:0]         col_eff;
    logic [SW-1:0]         sum;
    logic [DATA_WIDTH-1:0] pool;
    int unsigned           k;

    assign pixel_ready = (state_q == IDLE) || (state_q == FILL);
    assign accept      = pixel_valid && pixel_ready;
    assign start       = (state_q == START);
    assign busy        = (state_q != IDLE);
    assign pixels_out  = pixels_q;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        prev_d    = prev_q;
        partial_d = partial_q;
        pixels_d  = pixels_q;
        take      = 1'b0;
        row_eff   = row_q;
        col_eff   = col_q;
        sum       = '0;
        pool      = '0;
        k         = 0;

        unique case (state_q)
            IDLE:      take = accept && pixel_sof;
            FILL:      take = accept;
            START:     state_d = WAIT_DONE;
            WAIT_DONE: if (mlp_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        if (take) begin
            // SOF forces this pixel to be (0,0), in IDLE or as a mid-frame restart
            if (pixel_sof) begin
                row_eff = '0;
                col_eff = '0;
            end
            state_d = FILL;

            if (!col_eff[0]) begin
                prev_d = pixel_in;
            end else if (!row_eff[0]) begin
                partial_d[col_eff[CW-1:1]] = SW'(prev_q) + SW'(pixel_in);
            end else begin
                sum  = partial_q[col_eff[CW-1:1]] + SW'(prev_q) + SW'(pixel_in);
                pool = DATA_WIDTH'(sum >> POOL_SHIFT);
                k    = 32'(row_eff >> 1) * OUT_DIM + 32'(col_eff >> 1);
                pixels_d[W-1-DATA_WIDTH*k -: DATA_WIDTH] = pool;
            end

            if (col_eff == LAST) begin
                col_d = '0;
                if (row_eff == LAST) begin
                    row_d   = '0;
                    state_d = START;
                end else begin
                    row_d = row_eff + 1'b1;
                end
            end else begin
                col_d = col_eff + 1'b1;
                row_d = row_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            prev_q   <= '0;
            pixels_q <= '0;
            for (int i = 0; i < int'(OUT_DIM); i++) begin
                partial_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            prev_q    <= prev_d;
            pixels_q  <= pixels_d;
            partial_q <= partial_d;
        end
    end

endmodule

// File: tb/tb_pixel_pool_buffer.sv
// Directed bench for pixel_pool_buffer: uniform, block-pattern, sparse, anomaly and
// mid-frame-reset frames checked against hand-computed pooled images.
module tb_pixel_pool_buffer;

    localparam int unsigned W = 1568;

    logic         clk;
    logic         reset;
    logic [7:0]   pixel_in;
    logic         pixel_valid;
    logic         pixel_sof;
    logic         pixel_ready;
    logic         mlp_done;
    logic [W-1:0] pixels_out;
    logic         start;
    logic         busy;

    int unsigned  checks;
    int unsigned  passed;
    int unsigned  start_cnt;
    int unsigned  start_base;
    logic [W-1:0] snap;
    logic [W-1:0] expv;
    logic         hold_ok;

    pixel_pool_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_sof   (pixel_sof),
        .pixel_ready (pixel_ready),
        .mlp_done    (mlp_done),
        .pixels_out  (pixels_out),
        .start       (start),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) start_cnt <= 0;
        else if (start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int mode, input int r, input int c);
        case (mode)
            0: return 8'hFF;
            1: begin
                if (r < 2 && c < 2) return 8'd8;
                if (r == 0 && c == 2) return 8'd255;
                return 8'd0;
            end
            3: return 8'h10;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [W-1:0] fill_vec(input logic [7:0] v);
        logic [W-1:0] vv;
        for (int i = 0; i < 196; i++) vv[W-1-8*i -: 8] = v;
        return vv;
    endfunction

    // Sends n pixels of a frame starting with SOF; returns #1 after the last accept edge.
    task automatic send_frame(input int mode, input int n, input bit sparse);
        for (int i = 0; i < n; i++) begin
            if (sparse && $urandom_range(1) == 1) step();
            pixel_in    = pix(mode, i / 28, i % 28);
            pixel_sof   = (i == 0);
            pixel_valid = 1'b1;
            step();
            pixel_valid = 1'b0;
            pixel_sof   = 1'b0;
        end
    endtask

    task automatic frame_end_checks(input string tag);
        check({tag, "_start"}, W'(start), W'(1'b1));
        check({tag, "_ready"}, W'(pixel_ready), W'(1'b0));
        step();
        check({tag, "_start_off"}, W'(start), W'(1'b0));
        check({tag, "_busy"}, W'(busy), W'(1'b1));
        check({tag, "_start_cnt"}, W'(start_cnt - start_base), W'(1));
    endtask

    task automatic release_done(input string tag);
        mlp_done = 1'b1;
        step();
        mlp_done = 1'b0;
        check({tag, "_rel_busy"}, W'(busy), W'(1'b0));
        check({tag, "_rel_ready"}, W'(pixel_ready), W'(1'b1));
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        reset       = 1'b1;
        pixel_in    = '0;
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
        mlp_done    = 1'b0;
        step();
        check("rst_ready", W'(pixel_ready), W'(1'b1));
        check("rst_busy", W'(busy), W'(1'b0));
        check("rst_start", W'(start), W'(1'b0));
        check("rst_pixels", pixels_out, '0);
        reset = 1'b0;
        step();

        // Pixels with no SOF in IDLE are discarded
        for (int i = 0; i < 5; i++) begin
            pixel_in = 8'hAA;
            pixel_valid = 1'b1;
            step();
        end
        pixel_valid = 1'b0;
        check("nosof_busy", W'(busy), W'(1'b0));
        check("nosof_ready", W'(pixel_ready), W'(1'b1));
        check("nosof_pixels", pixels_out, '0);

        // Uniform 0xFF frame
        start_base = start_cnt;
        send_frame(0, 784, 1'b0);
        frame_end_checks("uni");
        check("uni_pixels", pixels_out, fill_vec(8'h7F));

        // Backpressure for 500 cycles
        snap    = pixels_out;
        hold_ok = 1'b1;
        pixel_in = 8'h55;
        pixel_valid = 1'b1;
        pixel_sof = 1'b1;
        for (int i = 0; i < 500; i++) begin
            step();
            if (pixel_ready !== 1'b0 || busy !== 1'b1 || pixels_out !== snap) hold_ok = 1'b0;
        end
        pixel_valid = 1'b0;
        pixel_sof = 1'b0;
        check("hold_stable", W'(hold_ok), W'(1'b1));
        check("hold_one_start", W'(start_cnt - start_base), W'(1));
        release_done("uni");

        // All-zero frame
        start_base = start_cnt;
        send_frame(2, 784, 1'b0);
        frame_end_checks("zero");
        check("zero_pixels", pixels_out, '0);
        release_done("zero");

        // Block pattern: idx0 = (8*4)>>3 = 4, idx1 = 255>>3 = 31
        start_base = start_cnt;
        send_frame(1, 784, 1'b0);
        frame_end_checks("blk");
        expv = '0;
        expv[W-1 -: 8] = 8'd4;
        expv[W-9 -: 8] = 8'd31;
        check("blk_idx0", W'(pixels_out[1567:1560]), W'(8'd4));
        check("blk_idx1", W'(pixels_out[1559:1552]), W'(8'd31));
        check("blk_pixels", pixels_out, expv);
        release_done("blk");

        // Sparse-valid uniform frame
        start_base = start_cnt;
        send_frame(0, 784, 1'b1);
        frame_end_checks("sparse");
        check("sparse_pixels", pixels_out, fill_vec(8'h7F));
        release_done("sparse");

        // SOF restart at pixel 300, then full frame of 0x10 -> 64>>3 = 8
        start_base = start_cnt;
        send_frame(0, 300, 1'b0);
        check("restart_nostart", W'(start_cnt - start_base), W'(0));
        send_frame(3, 784, 1'b0);
        frame_end_checks("restart");
        check("restart_pixels", pixels_out, fill_vec(8'h08));
        release_done("restart");

        // Reset after 400 pixels
        send_frame(0, 400, 1'b0);
        reset = 1'b1;
        step();
        check("mrst_pixels", pixels_out, '0);
        check("mrst_busy", W'(busy), W'(1'b0));
        check("mrst_start", W'(start), W'(1'b0));
        reset = 1'b0;
        repeat (10) step();
        check("mrst_no_start", W'(start_cnt), W'(0));
        start_base = start_cnt;
        send_frame(1, 784, 1'b0);
        frame_end_checks("post");
        check("post_pixels", pixels_out, expv);
        release_done("post");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
